// File: rtl/game_pkg.sv
// Shared types and constants for the three-pad target game sequencer.
// Pad k occupies sensor bits [5k+4:5k]; the top bit of each group is the bullseye.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_WAIT_HIT,
    S_SCORE,
    S_GAMEOVER
  } state_t;

  localparam int PAD_W    = 5;
  localparam int NUM_PADS = 3;
  localparam int SENS_W   = PAD_W * NUM_PADS;
  localparam int BULL_BIT = 4;
  localparam int RING_MSB = 3;
  localparam int RING_LSB = 0;
  localparam int SCORE_W  = 10;

  localparam logic [PAD_W-1:0]   PAD_RELEASED  = 5'b11111;
  localparam logic [SENS_W-1:0]  SENS_RELEASED = 15'h7FFF;
  localparam logic [SCORE_W-1:0] AWARD_BULL    = 10'd4;
  localparam logic [SCORE_W-1:0] AWARD_RING    = 10'd2;
  localparam logic [SCORE_W-1:0] SCORE_MAX     = 10'd1023;
  localparam logic [15:0]        LFSR_TAPS     = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  function automatic logic [1:0] pad_draw(input logic [7:0] l);
    logic [7:0] r;
    r = l % 8'd3;
    return r[1:0];
  endfunction

  function automatic logic [PAD_W-1:0] pad_group(input logic [SENS_W-1:0] s, input logic [1:0] pad);
    case (pad)
      2'd1:    return s[2*PAD_W-1:PAD_W];
      2'd2:    return s[3*PAD_W-1:2*PAD_W];
      default: return s[PAD_W-1:0];
    endcase
  endfunction

  // Bullseye outranks the ring, so a combined hit still earns only the bullseye award.
  function automatic logic [SCORE_W-1:0] pad_award(input logic [PAD_W-1:0] g);
    if (!g[BULL_BIT])                     return AWARD_BULL;
    else if (g[RING_MSB:RING_LSB] != '1)  return AWARD_RING;
    else                                  return '0;
  endfunction

endpackage

// File: rtl/game_round_sequencer_hiscore.sv
// Three-entry descending high-score table; one sorted insert per strobe.
// Equal scores never displace an existing entry.
module hiscore_table
  import game_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ins,
  input  logic [SCORE_W-1:0] i_score,
  output logic [SCORE_W-1:0] o_h1,
  output logic [SCORE_W-1:0] o_h2,
  output logic [SCORE_W-1:0] o_h3
);

  logic [SCORE_W-1:0] r_h1;
  logic [SCORE_W-1:0] r_h2;
  logic [SCORE_W-1:0] r_h3;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h1 <= '0;
      r_h2 <= '0;
      r_h3 <= '0;
    end else if (i_ins) begin
      if (i_score > r_h1) begin
        r_h3 <= r_h2;
        r_h2 <= r_h1;
        r_h1 <= i_score;
      end else if (i_score > r_h2) begin
        r_h3 <= r_h2;
        r_h2 <= i_score;
      end else if (i_score > r_h3) begin
        r_h3 <= i_score;
      end
    end
  end

  assign o_h1 = r_h1;
  assign o_h2 = r_h2;
  assign o_h3 = r_h3;

endmodule

// File: rtl/game_round_sequencer.sv
// Runs one target-game session: random pad draw, timed hit window, scoring and high-score upkeep.
// Outputs are registered except oPhase/oBusy/oGameOver, which decode the current state.
module game_round_sequencer
  import game_pkg::*;
#(
  parameter int          ROUND_TICKS = 31000000,
  parameter int          NUM_ROUNDS  = 20,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                iVGA_CLK,
  input  logic                iRST_n,
  input  logic                iStart,
  input  logic                iAbort,
  input  logic [SENS_W-1:0]   iSensor,
  output logic [2:0]          oLamp_n,
  output logic [1:0]          oPad,
  output logic [1:0]          oPhase,
  output logic [4:0]          oRound,
  output logic [SCORE_W-1:0]  oScore,
  output logic [SCORE_W-1:0]  oHigh1,
  output logic [SCORE_W-1:0]  oHigh2,
  output logic [SCORE_W-1:0]  oHigh3,
  output logic                oBusy,
  output logic                oGameOver
);

  localparam int              CNT_W       = $clog2(ROUND_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(ROUND_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_PH1    = CNT_W'(ROUND_TICKS / 3);
  localparam logic [CNT_W-1:0] CNT_PH2    = CNT_W'((2 * ROUND_TICKS) / 3);
  localparam logic [4:0]       ROUNDS_END = 5'(NUM_ROUNDS);

  state_t             r_state;
  state_t             w_next;
  logic [SENS_W-1:0]  r_sync1;
  logic [SENS_W-1:0]  r_sync2;
  logic [15:0]        r_lfsr;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_pad;
  logic [2:0]         r_lamp_n;
  logic [SCORE_W-1:0] r_award;
  logic [SCORE_W-1:0] r_score;
  logic [4:0]         r_round;

  logic [PAD_W-1:0]   w_group;
  logic               w_hit;
  logic               w_timeout;
  logic               w_released;
  logic [1:0]         w_draw;
  logic [SCORE_W:0]   w_sum;
  logic [SCORE_W-1:0] w_new_score;
  logic [4:0]         w_new_round;
  logic               w_ins;
  logic [1:0]         w_phase;

  assign w_group     = pad_group(r_sync2, r_pad);
  assign w_hit       = (w_group != PAD_RELEASED);
  assign w_timeout   = (r_cnt == CNT_LAST);
  assign w_released  = (r_sync2 == SENS_RELEASED);
  assign w_draw      = pad_draw(r_lfsr[7:0]);
  assign w_sum       = {1'b0, r_score} + {1'b0, r_award};
  assign w_new_score = w_sum[SCORE_W] ? SCORE_MAX : w_sum[SCORE_W-1:0];
  assign w_new_round = r_round + 5'd1;
  assign w_ins       = (r_state == S_SCORE) && (w_next == S_GAMEOVER);

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_sync1 <= SENS_RELEASED;
      r_sync2 <= SENS_RELEASED;
      r_lfsr  <= LFSR_SEED;
    end else begin
      r_sync1 <= iSensor;
      r_sync2 <= r_sync1;
      r_lfsr  <= lfsr_next(r_lfsr);
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Abort wins over everything; a hit landing on the timeout tick still leaves via the hit path.
  always_comb begin
    w_next = r_state;
    if (iAbort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (iStart) w_next = S_PICK;
        S_PICK:     if (w_released) w_next = S_WAIT_HIT;
        S_WAIT_HIT: if (w_hit || w_timeout) w_next = S_SCORE;
        S_SCORE:    w_next = (w_new_round == ROUNDS_END) ? S_GAMEOVER : S_PICK;
        S_GAMEOVER: if (iStart) w_next = S_PICK;
        default:    w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_cnt    <= '0;
      r_pad    <= '0;
      r_lamp_n <= 3'b111;
      r_award  <= '0;
      r_score  <= '0;
      r_round  <= '0;
    end else if (iAbort) begin
      r_lamp_n <= 3'b111;
      r_score  <= '0;
      r_round  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_GAMEOVER: begin
          if (iStart) begin
            r_score <= '0;
            r_round <= '0;
          end
        end
        S_PICK: begin
          if (w_released) begin
            r_pad    <= w_draw;
            r_lamp_n <= ~(3'b001 << w_draw);
            r_cnt    <= '0;
          end
        end
        S_WAIT_HIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_hit)          r_award <= pad_award(w_group);
          else if (w_timeout) r_award <= '0;
        end
        S_SCORE: begin
          r_score  <= w_new_score;
          r_round  <= w_new_round;
          r_lamp_n <= 3'b111;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_phase = 2'd3;
    if (r_state == S_WAIT_HIT) begin
      if (r_cnt < CNT_PH1)      w_phase = 2'd0;
      else if (r_cnt < CNT_PH2) w_phase = 2'd1;
      else                      w_phase = 2'd2;
    end
  end

  hiscore_table u_hiscore (
    .i_clk   (iVGA_CLK),
    .i_rst_n (iRST_n),
    .i_ins   (w_ins),
    .i_score (w_new_score),
    .o_h1    (oHigh1),
    .o_h2    (oHigh2),
    .o_h3    (oHigh3)
  );

  assign oLamp_n   = r_lamp_n;
  assign oPad      = r_pad;
  assign oPhase    = w_phase;
  assign oRound    = r_round;
  assign oScore    = r_score;
  assign oBusy     = (r_state == S_PICK) || (r_state == S_WAIT_HIT) || (r_state == S_SCORE);
  assign oGameOver = (r_state == S_GAMEOVER);

endmodule

// File: tb/tb_game_round_sequencer.sv
// Directed game sessions with randomized hit timing and sensor patterns,
// checked against a round-level reference model of score, pad draw and high-score table.
module tb_game_round_sequencer;

  localparam int          RT   = 30;
  localparam int          NR   = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [14:0] sensor = 15'h7FFF;
  logic [2:0]  lamp_n;
  logic [1:0]  pad, phase;
  logic [4:0]  round;
  logic [9:0]  score, h1, h2, h3;
  logic        busy, gameover;

  always #5 clk = ~clk;

  game_round_sequencer #(.ROUND_TICKS(RT), .NUM_ROUNDS(NR), .LFSR_SEED(SEED)) dut (
    .iVGA_CLK (clk),
    .iRST_n   (rst_n),
    .iStart   (start),
    .iAbort   (abort),
    .iSensor  (sensor),
    .oLamp_n  (lamp_n),
    .oPad     (pad),
    .oPhase   (phase),
    .oRound   (round),
    .oScore   (score),
    .oHigh1   (h1),
    .oHigh2   (h2),
    .oHigh3   (h3),
    .oBusy    (busy),
    .oGameOver(gameover)
  );

  // Free-running reference of the x^16+x^14+x^13+x^11 sequence.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  int n_cmp = 0;
  int n_bad = 0;
  int exp_score = 0;
  int exp_round = 0;
  int hs[3] = '{0, 0, 0};
  bit sens_held = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic hs_insert(input int s);
    int q[$];
    q = {hs[0], hs[1], hs[2], s};
    q.rsort();
    for (int i = 0; i < 3; i++) hs[i] = q[i];
  endtask

  task automatic check_hs(input string tag);
    chk({tag, ".h1"}, 32'(h1), hs[0]);
    chk({tag, ".h2"}, 32'(h2), hs[1]);
    chk({tag, ".h3"}, 32'(h3), hs[2]);
  endtask

  task automatic start_game();
    if (sens_held) begin
      sensor = 15'h7FFF;
      repeat (2) @(negedge clk);
      sens_held = 0;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_score = 0;
    exp_round = 0;
    chk("start.busy", 32'(busy), 1);
    chk("start.score", 32'(score), 0);
    chk("start.round", 32'(round), 0);
    chk("start.lamp", 32'(lamp_n), 7);
  endtask

  // kind: 0 timeout, 2 ring hit, 4 bullseye hit, 6 bullseye+ring together.
  // Entered on a falling edge with the DUT in PICK and all pads already released.
  task automatic play_round(input int kind, input bit noise, input int force_d);
    logic [7:0]  lb;
    logic [14:0] pat;
    logic [4:0]  g;
    int p, d, c_end, drive_k, award;
    lb = m_lfsr[7:0];
    p = int'(lb) % 3;
    award = (kind == 6) ? 4 : kind;
    @(negedge clk);
    chk("arm.lamp", 32'(lamp_n), 7 & ~(1 << p));
    chk("arm.pad", 32'(pad), p);

    pat = 15'h7FFF;
    if (noise)
      for (int q = 0; q < 3; q++)
        if (q != p) begin
          g = 5'($urandom_range(0, 30));
          pat[5*q +: 5] = g;
        end
    if (kind != 0) begin
      case (kind)
        2:       g = {1'b1, 4'($urandom_range(0, 14))};
        4:       g = 5'b01111;
        default: g = {1'b0, 4'($urandom_range(0, 14))};
      endcase
      pat[5*p +: 5] = g;
      d = (force_d >= 0) ? force_d : int'($urandom_range(0, RT - 3));
      c_end = d + 2;
      drive_k = d;
    end else begin
      c_end = RT - 1;
      drive_k = 0;
    end

    for (int k = 0; k <= c_end; k++) begin
      chk("wait.phase", 32'(phase), (k < RT / 3) ? 0 : (k < (2 * RT) / 3) ? 1 : 2);
      if (k == drive_k) sensor = pat;
      @(negedge clk);
    end
    chk("score_st.phase", 32'(phase), 3);
    chk("score_st.lamp", 32'(lamp_n), 7 & ~(1 << p));
    chk("score_st.busy", 32'(busy), 1);

    exp_score = (exp_score + award > 1023) ? 1023 : exp_score + award;
    exp_round++;
    sens_held = (pat != 15'h7FFF);
    @(negedge clk);
    chk("post.lamp", 32'(lamp_n), 7);
    chk("post.score", 32'(score), exp_score);
    chk("post.round", 32'(round), exp_round);
    if (exp_round == NR) begin
      chk("end.gameover", 32'(gameover), 1);
      chk("end.busy", 32'(busy), 0);
      hs_insert(exp_score);
      check_hs("end");
    end else begin
      chk("next.busy", 32'(busy), 1);
      chk("next.gameover", 32'(gameover), 0);
      if (sens_held) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          chk("stall.lamp", 32'(lamp_n), 7);
          chk("stall.phase", 32'(phase), 3);
        end
        sensor = 15'h7FFF;
        repeat (2) begin
          @(negedge clk);
          chk("release.lamp", 32'(lamp_n), 7);
        end
        sens_held = 0;
      end
    end
  endtask

  task automatic play_game(input int k0, input int k1, input int k2, input bit noise);
    start_game();
    play_round(k0, noise, -1);
    play_round(k1, noise, -1);
    play_round(k2, noise, -1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".lamp"}, 32'(lamp_n), 7);
    chk({tag, ".pad"}, 32'(pad), 0);
    chk({tag, ".phase"}, 32'(phase), 3);
    chk({tag, ".round"}, 32'(round), 0);
    chk({tag, ".score"}, 32'(score), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".gameover"}, 32'(gameover), 0);
    check_hs(tag);
  endtask

  initial begin
    logic [7:0]  lb;
    logic [14:0] pat;
    int p;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle.busy", 32'(busy), 0);

    // All timeouts, clean sensors: phase walk and a zero-score game that inserts nothing
    play_game(0, 0, 0, 0);

    // Scores 8, 12, 8, 10, 8 with randomized timing and non-armed noise
    start_game();
    play_round(6, 1, 0);
    play_round(4, 1, -1);
    play_round(0, 1, -1);
    start_game();
    play_round(4, 1, -1);
    play_round(6, 1, RT - 3);
    play_round(4, 0, -1);
    start_game();
    play_round(0, 1, -1);
    play_round(4, 1, -1);
    play_round(4, 1, RT - 3);
    play_game(2, 4, 4, 1);
    play_game(6, 2, 2, 1);

    // Abort coinciding with a hit in WAIT_HIT
    start_game();
    play_round(4, 0, -1);
    lb = m_lfsr[7:0];
    p = int'(lb) % 3;
    @(negedge clk);
    chk("abort.arm", 32'(lamp_n), 7 & ~(1 << p));
    pat = 15'h7FFF;
    pat[5*p +: 5] = 5'b01111;
    sensor = pat;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    sens_held = 1;
    chk("abort.busy", 32'(busy), 0);
    chk("abort.gameover", 32'(gameover), 0);
    chk("abort.lamp", 32'(lamp_n), 7);
    chk("abort.score", 32'(score), 0);
    chk("abort.round", 32'(round), 0);
    chk("abort.phase", 32'(phase), 3);
    check_hs("abort");
    @(negedge clk);
    chk("abort.stay_idle", 32'(busy), 0);

    // Asynchronous reset in the middle of a hit window
    start_game();
    @(negedge clk);
    chk("prereset.lamp_on", 32'(lamp_n == 3'b111), 0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 hs = '{0, 0, 0};
    exp_score = 0;
    exp_round = 0;
    check_reset_vals("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    play_game(6, 2, 4, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
